// File: rtl/register_file.sv
// register_file: 2^ADDR_W x WIDTH GPR array, r0 hardwired to zero.
// Two combinational read ports, one synchronous write port, no bypass.
module register_file #(
  parameter int WIDTH  = 32,
  parameter int ADDR_W = 5
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [ADDR_W-1:0] a1,
  input  logic [ADDR_W-1:0] a2,
  input  logic [ADDR_W-1:0] a3,
  input  logic              we3,
  input  logic [WIDTH-1:0]  wd3,
  output logic [WIDTH-1:0]  rd1,
  output logic [WIDTH-1:0]  rd2
);

  localparam int NREG = 1 << ADDR_W;

  logic [WIDTH-1:0] mem [NREG];

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < NREG; i++) begin
        mem[i] <= '0;
      end
    end else begin
      assert (!$isunknown({we3, a3}));
      // writes to r0 are dropped so mem[0] stays at its reset value
      if (we3 && (a3 != '0)) begin
        mem[a3] <= wd3;
      end
    end
  end

  // Read straight from the array: the old value is seen during a write.
  assign rd1 = (reset || (a1 == '0)) ? '0 : mem[a1];
  assign rd2 = (reset || (a2 == '0)) ? '0 : mem[a2];

endmodule

// File: tb/tb_register_file.sv
// tb_register_file: directed checks of reset, write/read, r0,
// reset-vs-write priority, no-bypass and a full 32-register sweep.
module tb_register_file;

  logic        clk;
  logic        reset;
  logic [4:0]  a1;
  logic [4:0]  a2;
  logic [4:0]  a3;
  logic        we3;
  logic [31:0] wd3;
  logic [31:0] rd1;
  logic [31:0] rd2;

  int checks = 0;
  int errors = 0;

  register_file #(.WIDTH(32), .ADDR_W(5)) dut (
    .clk   (clk),
    .reset (reset),
    .a1    (a1),
    .a2    (a2),
    .a3    (a3),
    .we3   (we3),
    .wd3   (wd3),
    .rd1   (rd1),
    .rd2   (rd2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag,
                       input logic [31:0] obs,
                       input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic wr(input logic [4:0] addr, input logic [31:0] data);
    a3  = addr;
    wd3 = data;
    we3 = 1'b1;
    tick();
    we3 = 1'b0;
  endtask

  initial begin
    reset = 1'b1;
    we3   = 1'b0;
    a1    = 5'd5;
    a2    = 5'd7;
    a3    = 5'd0;
    wd3   = '0;
    #1;
    check("rd1_in_reset_pre", rd1, 32'h0);
    check("rd2_in_reset_pre", rd2, 32'h0);
    tick();
    check("rd1_in_reset", rd1, 32'h0);
    reset = 1'b0;
    #1;
    check("r5_after_reset", rd1, 32'h0);
    check("r7_after_reset", rd2, 32'h0);

    // reset clear
    wr(5'd5, 32'hDEADBEEF);
    #1;
    check("r5_written", rd1, 32'hDEADBEEF);
    reset = 1'b1;
    #1;
    check("rd1_forced_zero", rd1, 32'h0);
    tick();
    reset = 1'b0;
    #1;
    check("r5_cleared", rd1, 32'h0);

    // write/read on both ports
    a1  = 5'd8;
    a2  = 5'd8;
    a3  = 5'd8;
    wd3 = 32'h12345678;
    we3 = 1'b1;
    #1;
    check("r8_old_p1", rd1, 32'h0);
    check("r8_old_p2", rd2, 32'h0);
    tick();
    we3 = 1'b0;
    #1;
    check("r8_new_p1", rd1, 32'h12345678);
    check("r8_new_p2", rd2, 32'h12345678);

    // r0 immutability
    wr(5'd0, 32'hFFFFFFFF);
    for (int i = 0; i < 32; i++) begin
      a1 = 5'(i);
      a2 = 5'(31 - i);
      #1;
      check($sformatf("r0sweep_r%0d", i), rd1,
            (i == 8) ? 32'h12345678 : 32'h0);
      check($sformatf("r0sweep_p2_r%0d", 31 - i), rd2,
            ((31 - i) == 8) ? 32'h12345678 : 32'h0);
    end

    // reset beats a simultaneous write
    wr(5'd3, 32'h00000011);
    a1 = 5'd3;
    #1;
    check("r3_pre_collision", rd1, 32'h00000011);
    reset = 1'b1;
    a3    = 5'd3;
    wd3   = 32'hA5A5A5A5;
    we3   = 1'b1;
    tick();
    reset = 1'b0;
    we3   = 1'b0;
    a2    = 5'd8;
    #1;
    check("r3_collision", rd1, 32'h0);
    check("r8_collision", rd2, 32'h0);

    // no write-to-read bypass
    wr(5'd9, 32'h00000010);
    a1  = 5'd9;
    a3  = 5'd9;
    wd3 = 32'h00000020;
    we3 = 1'b1;
    #1;
    check("nobypass_before", rd1, 32'h00000010);
    tick();
    we3 = 1'b0;
    #1;
    check("nobypass_after", rd1, 32'h00000020);

    // back-to-back writes to one address
    a1  = 5'd10;
    a3  = 5'd10;
    wd3 = 32'h1;
    we3 = 1'b1;
    tick();
    check("b2b_first", rd1, 32'h1);
    wd3 = 32'h2;
    tick();
    we3 = 1'b0;
    #1;
    check("b2b_second", rd1, 32'h2);

    // reset released with a write pending
    reset = 1'b1;
    a1    = 5'd4;
    a3    = 5'd4;
    wd3   = 32'h44;
    we3   = 1'b1;
    tick();
    reset = 1'b0;
    #1;
    check("release_pre", rd1, 32'h0);
    tick();
    we3 = 1'b0;
    #1;
    check("release_write", rd1, 32'h44);

    // full sweep
    for (int i = 1; i < 32; i++) begin
      wr(5'(i), 32'(i) * 32'h01010101);
    end
    for (int i = 0; i < 32; i++) begin
      a1 = 5'(i);
      a2 = 5'(31 - i);
      #1;
      check($sformatf("sweep_p1_r%0d", i), rd1,
            32'(i) * 32'h01010101);
      check($sformatf("sweep_p2_r%0d", 31 - i), rd2,
            32'(31 - i) * 32'h01010101);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
